// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcodes, FSM states,
// HI/LO write-mask encodings and a small opcode classifier.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FIXUP = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  localparam logic [1:0] HILO_WR_NONE = 2'b00;
  localparam logic [1:0] HILO_WR_HI   = 2'b10;
  localparam logic [1:0] HILO_WR_LO   = 2'b01;
  localparam logic [1:0] HILO_WR_BOTH = 2'b11;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute stage (master) and muldiv_unit (slave).
// start is a valid with implicit ready = !busy: a request is taken on any edge where
// start=1 and busy=0, and dropped otherwise. hilo_write is a one-cycle strobe, no ready.
interface muldiv_if #(parameter int WIDTH = 32) ();
  import muldiv_pkg::*;

  logic                 start;
  logic [2:0]           op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 cancel;
  logic                 busy;
  logic [2*WIDTH-1:0]   hilo_d;
  logic [1:0]           hilo_write;
  state_e               dbg_state;

  modport master (
    output start, op, a, b, cancel,
    input  busy, hilo_d, hilo_write, dbg_state
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, hilo_d, hilo_write, dbg_state
  );

endinterface

// File: rtl/muldiv_core.sv
// Iteration datapath: shift-add multiplier and restoring divider on unsigned magnitudes,
// sharing one 2*WIDTH accumulator ({hi,lo} for multiply, {remainder,quotient} for divide).
module muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 is_div_i,
  input  logic [WIDTH-1:0]     a_mag_i,
  input  logic [WIDTH-1:0]     b_mag_i,
  output logic [2*WIDTH-1:0]   acc_o,
  output logic                 last_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   aux_q, aux_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;

  assign last_o = (cnt_q == CW'(WIDTH - 1));
  assign acc_o  = acc_q;

  always_comb begin
    acc_d    = acc_q;
    aux_d    = aux_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, aux_q} : {(WIDTH+1){1'b0}});
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, aux_q};
    if (load_i) begin
      is_div_d = is_div_i;
      acc_d    = {{WIDTH{1'b0}}, (is_div_i ? a_mag_i : b_mag_i)};
      aux_d    = is_div_i ? b_mag_i : a_mag_i;
      cnt_d    = '0;
    end else if (step_i) begin
      // Divide: a borrow (div_diff[WIDTH]) means restore and shift in a 0 quotient bit.
      if (is_div_q) begin
        acc_d = {(div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
      end else begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      aux_q    <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      aux_q    <= aux_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO producer: FSM, sign handling and registered outputs around muldiv_core.
// MTHI/MTLO write straight from IDLE; mult/div take WIDTH run cycles plus fixup and write.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  import muldiv_pkg::*;

  state_e               state_q, state_d;
  logic                 busy_q, busy_d;
  logic [1:0]           hw_q, hw_d;
  logic [2*WIDTH-1:0]   hd_q, hd_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 div_zero_q, div_zero_d;
  logic                 is_div_q, is_div_d;
  logic [WIDTH-1:0]     a_raw_q, a_raw_d;

  logic                 core_load, core_step, core_last;
  logic                 req_div, req_signed, a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quot_fix, rem_fix;

  assign req_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign req_signed = op_is_signed(bus.op);
  assign a_neg      = req_signed & bus.a[WIDTH-1];
  assign b_neg      = req_signed & bus.b[WIDTH-1];
  assign a_mag      = a_neg ? -bus.a : bus.a;
  assign b_mag      = b_neg ? -bus.b : bus.b;

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load_i   (core_load),
    .step_i   (core_step),
    .is_div_i (req_div),
    .a_mag_i  (a_mag),
    .b_mag_i  (b_mag),
    .acc_o    (acc),
    .last_o   (core_last)
  );

  // Divide-by-zero overrides the unsigned result so both signed and unsigned give q=~0, r=a.
  assign prod_fix = neg_res_q ? -acc : acc;
  assign quot_fix = div_zero_q ? {WIDTH{1'b1}} :
                    (neg_res_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign rem_fix  = div_zero_q ? a_raw_q :
                    (neg_rem_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]);

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    hw_d       = HILO_WR_NONE;
    hd_d       = hd_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    is_div_d   = is_div_q;
    a_raw_d    = a_raw_q;
    core_load  = 1'b0;
    core_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MTHI: begin
              hd_d = {bus.a, bus.a};
              hw_d = HILO_WR_HI;
            end
            OP_MTLO: begin
              hd_d = {bus.a, bus.a};
              hw_d = HILO_WR_LO;
            end
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              core_load  = 1'b1;
              busy_d     = 1'b1;
              state_d    = ST_RUN;
              is_div_d   = req_div;
              neg_res_d  = a_neg ^ b_neg;
              neg_rem_d  = a_neg;
              div_zero_d = req_div && (bus.b == '0);
              a_raw_d    = bus.a;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (bus.cancel) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          core_step = 1'b1;
          if (core_last) state_d = ST_FIXUP;
        end
      end
      ST_FIXUP: begin
        if (bus.cancel) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          hd_d    = is_div_q ? {rem_fix, quot_fix} : prod_fix;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        hw_d    = HILO_WR_BOTH;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      hw_q       <= HILO_WR_NONE;
      hd_q       <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      is_div_q   <= 1'b0;
      a_raw_q    <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      hw_q       <= hw_d;
      hd_q       <= hd_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      is_div_q   <= is_div_d;
      a_raw_q    <= a_raw_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.hilo_write = hw_q;
  assign bus.hilo_d     = hd_q;
  assign bus.dbg_state  = state_q;

endmodule
